// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared memory bus widths, access kinds and counter helpers
package mem_bus_pkg;

    localparam int MEM_AW_DEF = 16;
    localparam int MEM_DW_DEF = 32;
    localparam int CNT_W      = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_kind_e;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - RD_LAT-deep read valid/data delay line
module mem_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int MEM_DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    input  logic [MEM_DW-1:0] data_i,
    output logic              vld_o,
    output logic [MEM_DW-1:0] data_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [MEM_DW-1:0] data_q [RD_LAT];
    logic [MEM_DW-1:0] data_d [RD_LAT];

    // Shift one stage per clock; data is zeroed on entry when there is no read
    // so the output data is zero whenever the output valid is low.
    always_comb begin
        vld_d     = '0;
        data_d[0] = '0;
        vld_d[0]  = vld_i;
        data_d[0] = vld_i ? data_i : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    // Stage registers; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q[RD_LAT-1];
    assign data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory responder with preload port and counters
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int MEM_AW     = MEM_AW_DEF,
    parameter int MEM_DW     = MEM_DW_DEF,
    parameter int DEPTH_BITS = 10,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_write,
    input  logic [MEM_AW-1:0]     mem_addr,
    input  logic [MEM_DW-1:0]     mem_wdata,
    output logic                  mem_rdata_vld,
    output logic [MEM_DW-1:0]     mem_rdata,
    output logic                  mem_err,
    input  logic                  ld_we,
    input  logic [DEPTH_BITS-1:0] ld_addr,
    input  logic [MEM_DW-1:0]     ld_wdata,
    output logic                  ld_drop,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      wr_cnt
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [MEM_DW-1:0]     mem_q [DEPTH];

    acc_kind_e             acc_kind;
    logic                  in_range;
    logic [DEPTH_BITS-1:0] idx;
    logic [MEM_DW-1:0]     rd_data_c;
    logic                  ld_collide;

    cnt_t                  rd_cnt_q, rd_cnt_d;
    cnt_t                  wr_cnt_q, wr_cnt_d;
    logic                  mem_err_q, mem_err_d;
    logic                  ld_drop_q, ld_drop_d;

    // Decode the bus access of this cycle and fetch the addressed word.
    always_comb begin
        acc_kind   = ACC_IDLE;
        if (mem_req) begin
            acc_kind = mem_write ? ACC_WRITE : ACC_READ;
        end
        in_range   = ((mem_addr >> DEPTH_BITS) == '0);
        idx        = mem_addr[DEPTH_BITS-1:0];
        rd_data_c  = in_range ? mem_q[idx] : '0;
        ld_collide = ld_we && mem_req;
    end

    // Storage is not reset; the bus always wins over the preload port.
    always_ff @(posedge clk) begin
        if (acc_kind == ACC_WRITE) begin
            if (in_range) begin
                mem_q[idx] <= mem_wdata;
            end
        end else if (ld_we && !mem_req) begin
            mem_q[ld_addr] <= ld_wdata;
        end
    end

    // Next state of counters and sticky flags; clear beats any update.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        mem_err_d = mem_err_q;
        ld_drop_d = ld_drop_q;
        if (cnt_clr) begin
            rd_cnt_d  = '0;
            wr_cnt_d  = '0;
            mem_err_d = 1'b0;
            ld_drop_d = 1'b0;
        end else begin
            if (acc_kind == ACC_READ) begin
                rd_cnt_d = sat_inc(rd_cnt_q);
            end
            if (acc_kind == ACC_WRITE) begin
                wr_cnt_d = sat_inc(wr_cnt_q);
            end
            if (mem_req && !in_range) begin
                mem_err_d = 1'b1;
            end
            if (ld_collide) begin
                ld_drop_d = 1'b1;
            end
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            mem_err_q <= 1'b0;
            ld_drop_q <= 1'b0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            mem_err_q <= mem_err_d;
            ld_drop_q <= ld_drop_d;
        end
    end

    mem_rd_pipe #(
        .RD_LAT (RD_LAT),
        .MEM_DW (MEM_DW)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (acc_kind == ACC_READ),
        .data_i (rd_data_c),
        .vld_o  (mem_rdata_vld),
        .data_o (mem_rdata)
    );

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign mem_err = mem_err_q;
    assign ld_drop = ld_drop_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized reference-model bench for mem_responder at RD_LAT 1, 2 and 4
module tb_mem_responder;

    localparam int NDUT = 3;
    localparam int LAT [NDUT] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        ld_we = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_wdata = '0;
    logic        cnt_clr = 1'b0;

    logic        o_vld   [NDUT];
    logic [31:0] o_rdata [NDUT];
    logic        o_err   [NDUT];
    logic        o_drop  [NDUT];
    logic [31:0] o_rdcnt [NDUT];
    logic [31:0] o_wrcnt [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_responder #(
            .MEM_AW     (16),
            .MEM_DW     (32),
            .DEPTH_BITS (10),
            .RD_LAT     (LAT[g])
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .mem_req       (mem_req),
            .mem_write     (mem_write),
            .mem_addr      (mem_addr),
            .mem_wdata     (mem_wdata),
            .mem_rdata_vld (o_vld[g]),
            .mem_rdata     (o_rdata[g]),
            .mem_err       (o_err[g]),
            .ld_we         (ld_we),
            .ld_addr       (ld_addr),
            .ld_wdata      (ld_wdata),
            .ld_drop       (o_drop[g]),
            .cnt_clr       (cnt_clr),
            .rd_cnt        (o_rdcnt[g]),
            .wr_cnt        (o_wrcnt[g])
        );
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected-response queues tagged with the edge index at
    // which each pulse must be visible, plus a plain array image of storage.
    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t       rq [NDUT][$];
    logic [31:0] ref_mem [1024];
    logic [31:0] m_rd, m_wr;
    logic        m_err, m_drop;
    int          cyc = 0;

    always @(posedge clk) begin
        logic in_rng;
        cyc++;
        if (rst_n) begin
            in_rng = (mem_addr < 16'd1024);
            if (mem_req && !mem_write) begin
                for (int k = 0; k < NDUT; k++) begin
                    rq[k].push_back('{cyc + LAT[k] - 1, in_rng ? ref_mem[mem_addr[9:0]] : 32'h0});
                end
            end
            if (mem_req && mem_write && in_rng) ref_mem[mem_addr[9:0]] = mem_wdata;
            if (ld_we && !mem_req) ref_mem[ld_addr] = ld_wdata;
            if (cnt_clr) begin
                m_rd = 0; m_wr = 0; m_err = 0; m_drop = 0;
            end else begin
                if (mem_req && !mem_write && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
                if (mem_req && mem_write && m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
                if (mem_req && !in_rng) m_err = 1'b1;
                if (ld_we && mem_req) m_drop = 1'b1;
            end
        end
    end

    // Compare every DUT against the model mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            logic        ev;
            logic [31:0] ed;
            ev = 1'b0;
            ed = 32'h0;
            if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
                ev = 1'b1;
                ed = rq[k][0].data;
                void'(rq[k].pop_front());
            end
            check($sformatf("vld_L%0d", LAT[k]),   64'(o_vld[k]),   64'(ev));
            check($sformatf("rdata_L%0d", LAT[k]), 64'(o_rdata[k]), 64'(ed));
            check($sformatf("err_L%0d", LAT[k]),   64'(o_err[k]),   64'(m_err));
            check($sformatf("drop_L%0d", LAT[k]),  64'(o_drop[k]),  64'(m_drop));
            check($sformatf("rdcnt_L%0d", LAT[k]), 64'(o_rdcnt[k]), 64'(m_rd));
            check($sformatf("wrcnt_L%0d", LAT[k]), 64'(o_wrcnt[k]), 64'(m_wr));
        end
    end

    task automatic drive(input logic rst, input logic req, input logic wr,
                         input logic [15:0] addr, input logic [31:0] wd,
                         input logic lwe, input logic [9:0] la, input logic [31:0] lwd,
                         input logic clr);
        @(negedge clk);
        #1;
        if (!rst) begin
            for (int k = 0; k < NDUT; k++) rq[k].delete();
            m_rd = 0; m_wr = 0; m_err = 0; m_drop = 0;
        end
        rst_n = rst; mem_req = req; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        ld_we = lwe; ld_addr = la; ld_wdata = lwd; cnt_clr = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [15:0] a);
        drive(1, 1, 0, a, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        drive(1, 1, 1, a, d, 0, 0, 0, 0);
    endtask

    initial begin
        m_rd = 0; m_wr = 0; m_err = 0; m_drop = 0;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Give every word a defined value through the preload port.
        for (int i = 0; i < 1024; i++) drive(1, 0, 0, 0, 0, 1, 10'(i), $urandom, 0);
        drive(1, 0, 0, 0, 0, 1, 10'd0, 32'h11, 0);
        drive(1, 0, 0, 0, 0, 1, 10'd1, 32'h22, 0);
        drive(1, 0, 0, 0, 0, 1, 10'd2, 32'h33, 0);
        drive(1, 0, 0, 0, 0, 1, 10'd3, 32'h44, 0);
        for (int i = 0; i < 4; i++) rd(16'(i));
        idle(6);

        // Write then immediate read-back with fresh counters.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        wr(16'd5, 32'hDEAD_BEEF);
        rd(16'd5);
        idle(6);

        // Out-of-range read and write, storage at the aliased index untouched.
        rd(16'h0400);
        wr(16'h8000, 32'hBAD0_BAD0);
        rd(16'h0000);
        idle(6);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Preload colliding with a bus read is dropped.
        drive(1, 1, 0, 16'd7, 0, 1, 10'd9, 32'h9999_9999, 0);
        rd(16'd9);
        idle(6);

        // Reads in flight are discarded by reset.
        rd(16'd1); rd(16'd2); rd(16'd3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(8);

        // Alternating A/B operand stream, 16 back-to-back reads.
        for (int i = 0; i < 16; i++) rd((i % 2 == 0) ? 16'(16'h100 + i / 2) : 16'(16'h200 + i / 2));
        idle(6);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 9) == 0) ? (16'($urandom) | 16'h0400) : 16'($urandom_range(0, 1023));
            drive(1, $urandom_range(0, 99) < 70, $urandom_range(0, 2) == 0, a, $urandom,
                  $urandom_range(0, 3) == 0, 10'($urandom_range(0, 1023)), $urandom,
                  $urandom_range(0, 63) == 0);
        end
        idle(8);

        for (int k = 0; k < NDUT; k++) check($sformatf("drain_L%0d", LAT[k]), 64'(rq[k].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, memory address width.
REQ-002 SHALL have parameter MEM_DW, default 32, memory data width.
REQ-003 SHALL have parameter DEPTH_BITS, default 10, log2 of storage words (DEPTH_BITS <= MEM_AW).
REQ-004 SHALL have parameter RD_LAT, default 2, read latency in cycles, legal range 1..4.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_req  in  1  access request this cycle.
- mem_write  in  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  in  MEM_AW  word address.
- mem_wdata  in  MEM_DW  write data.
- mem_rdata_vld  out  1  read data valid, one pulse per read.
- mem_rdata  out  MEM_DW  read data.
- mem_err  out  1  sticky out-of-range access flag.
- ld_we  in  1  preload write strobe.
- ld_addr  in  DEPTH_BITS  preload address.
- ld_wdata  in  MEM_DW  preload data.
- ld_drop  out  1  sticky flag, preload lost to a bus collision.
- cnt_clr  in  1  synchronous clear of counters and sticky flags.
- rd_cnt  out  32  reads accepted.
- wr_cnt  out  32  writes accepted.

Function
REQ-006 SHALL accept one request on every rising clk edge where mem_req=1; there is no ready/stall, and back-to-back requests every cycle SHALL all be serviced.
REQ-007 A read sampled at edge T SHALL produce mem_rdata_vld=1 with its data during the cycle following edge T+RD_LAT-1, i.e. exactly RD_LAT edges later, for exactly one cycle.
REQ-008 Read responses SHALL return in request order; N reads produce exactly N vld pulses.
REQ-009 mem_rdata SHALL be 0 whenever mem_rdata_vld=0.
REQ-010 A write sampled at edge T SHALL update storage at edge T; a read sampled at T+1 or later to the same address SHALL return the new data (no stale read-after-write).
REQ-011 Address is in range iff mem_addr[MEM_AW-1:DEPTH_BITS]==0; storage is indexed by mem_addr[DEPTH_BITS-1:0].
REQ-012 An out-of-range read SHALL still return a vld pulse with data 0 and set mem_err; an out-of-range write SHALL be dropped and set mem_err.
REQ-013 Preload SHALL write ld_wdata to ld_addr on edges where ld_we=1 and mem_req=0.
REQ-014 When ld_we=1 and mem_req=1 on the same edge, the bus access SHALL proceed, the preload SHALL be dropped, and ld_drop SHALL set.
REQ-015 rd_cnt/wr_cnt SHALL increment per accepted read/write (in- or out-of-range) and saturate at 0xFFFF_FFFF.
REQ-016 cnt_clr=1 SHALL zero rd_cnt, wr_cnt, mem_err and ld_drop at that edge, with priority over any increment or set on the same edge; it SHALL NOT affect the read pipeline.

Reset
REQ-017 rst_n=0 SHALL immediately force mem_rdata_vld=0, mem_rdata=0, mem_err=0, ld_drop=0, rd_cnt=0, wr_cnt=0 and clear all in-flight read slots.
REQ-018 Reads in flight at reset assertion SHALL be discarded; no vld pulse SHALL follow reset deassertion without a new request.
REQ-019 Storage contents SHALL NOT be reset and are undefined until written.

Structure
REQ-020 Default widths (MEM_AW, MEM_DW) and counter width 32 SHALL live in shared package mem_bus_pkg, used by both the bus initiator and this block.
REQ-021 The RD_LAT-deep valid/data delay line SHALL be a sub-module mem_rd_pipe (parameters RD_LAT, MEM_DW).

Verification
REQ-022 Preload addr 0..3 with 0x11,0x22,0x33,0x44, then reads to 0,1,2,3 on consecutive cycles, RD_LAT=2 -> four consecutive vld pulses, data 0x11..0x44, first pulse 2 edges after first request.
REQ-023 Write 0xDEAD_BEEF to addr 5, read addr 5 next cycle -> returns 0xDEAD_BEEF; rd_cnt=1, wr_cnt=1.
REQ-024 DEPTH_BITS=10: read addr 0x0400 and write addr 0x8000 -> read returns vld with data 0, mem_err=1, storage unchanged; cnt_clr -> mem_err=0, counters 0.
REQ-025 ld_we=1 with mem_req=1 read of addr 7 -> read serviced, addr ld_addr unchanged, ld_drop=1.
REQ-026 Issue 3 reads, assert rst_n=0 one cycle later, release -> no vld pulses after release; all outputs 0.
REQ-027 Sweep RD_LAT=1 and 4 with a matmul-style alternating A/B read stream of 16 words -> latency and order match REQ-007/008 per pulse.
